// File: rtl/ifu_fetch_stage.sv
// Instruction-fetch stage: PC owner, single-outstanding fetch FSM, IF/ID register.
// Optional IFU_MISALIGN_EXC_EN: misaligned redirects raise if_id_exc_o instead of fetching.
module ifu_fetch_stage #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
  parameter int unsigned     INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        stall_i,
  input  logic [5:0]        flush_i,
  input  logic              redirect_valid_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              if_req_valid_o,
  output logic [XLEN-1:0]   if_req_addr_o,
  input  logic              if_req_ready_i,
  input  logic              if_rsp_valid_i,
  input  logic [INST_W-1:0] if_rsp_data_i,
  output logic              ram_stall_valid_if_o,
  output logic              if_id_valid_o,
  output logic [XLEN-1:0]   if_id_pc_o,
  output logic [INST_W-1:0] if_id_inst_o,
  output logic              if_id_exc_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

  state_t              r_state, w_state_nxt;
  logic [XLEN-1:0]     r_pc, w_pc_nxt;
  logic                r_drop, w_drop_nxt;
  logic                r_buf_valid, w_buf_valid_nxt;
  logic [INST_W-1:0]   r_buf_inst;
  logic                r_mis, w_mis_nxt;
  logic                r_exc_pend, w_exc_pend_nxt;
  logic                r_if_id_valid;
  logic [XLEN-1:0]     r_if_id_pc;
  logic [INST_W-1:0]   r_if_id_inst;

  logic                w_hs, w_rsp_take, w_avail, w_misalign, w_load;
  logic [XLEN-1:0]     w_redirect_pc;
  logic [INST_W-1:0]   w_slot_inst;
  logic                w_unused;

`ifdef IFU_MISALIGN_EXC_EN
  logic r_if_id_exc;
  assign w_redirect_pc = redirect_pc_i;
  assign w_misalign    = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
  assign if_id_exc_o   = r_if_id_exc;
  assign w_unused      = ^{stall_i[5:2], flush_i[5:2], flush_i[0]};
`else
  assign w_redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign w_misalign    = 1'b0;
  assign if_id_exc_o   = 1'b0;
  assign w_unused      = ^{stall_i[5:2], flush_i[5:2], flush_i[0], redirect_pc_i[1:0]};
`endif

  assign w_hs        = (r_state == S_REQ) && if_req_ready_i;
  assign w_rsp_take  = (r_state == S_WAIT) && if_rsp_valid_i && !r_drop;
  assign w_avail     = r_buf_valid || w_rsp_take || r_exc_pend;
  assign w_load      = !(flush_i[1] || redirect_valid_i) && !stall_i[1] && w_avail;
  // The slot PC is always r_pc: the PC only advances once its instruction leaves.
  assign w_slot_inst = r_buf_valid ? r_buf_inst : (r_exc_pend ? NOP : if_rsp_data_i);

  assign if_req_valid_o       = (r_state == S_REQ);
  assign if_req_addr_o        = r_pc;
  assign ram_stall_valid_if_o = ((r_state == S_REQ) || (r_state == S_WAIT)) && !w_avail;
  assign if_id_valid_o        = r_if_id_valid;
  assign if_id_pc_o           = r_if_id_pc;
  assign if_id_inst_o         = r_if_id_inst;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_drop_nxt      = r_drop;
    w_buf_valid_nxt = r_buf_valid;
    w_mis_nxt       = r_mis;
    w_exc_pend_nxt  = r_exc_pend && !w_load;
    case (r_state)
      S_IDLE: if (!r_mis) w_state_nxt = S_REQ;
      S_REQ:  if (w_hs) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (if_rsp_valid_i) begin
          if (r_drop) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else if (!stall_i[0]) begin
            w_pc_nxt    = r_pc + XLEN'(4);
            w_state_nxt = S_REQ;
          end else begin
            w_buf_valid_nxt = 1'b1;
            w_state_nxt     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall_i[0]) begin
          w_pc_nxt        = r_pc + XLEN'(4);
          w_buf_valid_nxt = 1'b0;
          w_state_nxt     = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A redirect overrides the normal update; an accepted request must still drain.
    if (redirect_valid_i) begin
      w_pc_nxt        = w_redirect_pc;
      w_buf_valid_nxt = 1'b0;
      w_mis_nxt       = w_misalign;
      w_exc_pend_nxt  = w_misalign;
      case (r_state)
        S_WAIT: begin
          w_drop_nxt  = !if_rsp_valid_i;
          w_state_nxt = if_rsp_valid_i ? S_REQ : S_WAIT;
        end
        S_REQ: begin
          w_drop_nxt  = w_hs;
          w_state_nxt = w_hs ? S_WAIT : S_REQ;
        end
        default: w_state_nxt = S_REQ;
      endcase
      if (w_misalign) begin
        w_drop_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_drop      <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_inst  <= '0;
      r_mis       <= 1'b0;
      r_exc_pend  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_drop      <= w_drop_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_mis       <= w_mis_nxt;
      r_exc_pend  <= w_exc_pend_nxt;
      if (w_rsp_take) r_buf_inst <= if_rsp_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= '0;
      r_if_id_inst  <= '0;
    end else if (flush_i[1] || redirect_valid_i) begin
      r_if_id_valid <= 1'b0;
    end else if (!stall_i[1]) begin
      r_if_id_valid <= w_avail;
      if (w_avail) begin
        r_if_id_pc   <= r_pc;
        r_if_id_inst <= w_slot_inst;
      end
    end
  end

`ifdef IFU_MISALIGN_EXC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_if_id_exc <= 1'b0;
    else if (w_load) r_if_id_exc <= r_exc_pend;
  end
`endif

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Directed self-checking bench for ifu_fetch_stage; scenario tasks run back to back.
module tb_ifu_fetch_stage;

  logic        clk, rst_n;
  logic [5:0]  stall, flush;
  logic        redir_v;
  logic [63:0] redir_pc;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        ready, rsp_valid;
  logic [31:0] rsp_data;
  logic        ram_stall, id_valid, id_exc;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  int          checks = 0;
  int          errors = 0;

  ifu_fetch_stage #(.XLEN(64), .RESET_PC(64'h8000_0000), .INST_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
    .redirect_valid_i(redir_v), .redirect_pc_i(redir_pc),
    .if_req_valid_o(req_valid), .if_req_addr_o(req_addr), .if_req_ready_i(ready),
    .if_rsp_valid_i(rsp_valid), .if_rsp_data_i(rsp_data),
    .ram_stall_valid_if_o(ram_stall), .if_id_valid_o(id_valid),
    .if_id_pc_o(id_pc), .if_id_inst_o(id_inst), .if_id_exc_o(id_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; stall = '0; flush = '0; redir_v = 1'b0; redir_pc = '0;
    ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    tick; tick; #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", req_valid); end
    checks++; if (ram_stall !== 1'b0) begin errors++; $display("FAIL rst_ram_stall got %b exp 0", ram_stall); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid got %b exp 0", id_valid); end
    checks++; if (id_pc !== 64'h0) begin errors++; $display("FAIL rst_id_pc got %h exp 0", id_pc); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL rst_id_inst got %h exp 0", id_inst); end
    checks++; if (id_exc !== 1'b0) begin errors++; $display("FAIL rst_id_exc got %b exp 0", id_exc); end
    rst_n = 1'b1;
  endtask

  task automatic test_first_fetch;
    tick; #1;
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL ff_req_valid got %b exp 1", req_valid); end
    checks++; if (req_addr !== 64'h8000_0000) begin errors++; $display("FAIL ff_addr0 got %h exp 80000000", req_addr); end
    checks++; if (ram_stall !== 1'b1) begin errors++; $display("FAIL ff_stall_req got %b exp 1", ram_stall); end
    tick;
    rsp_valid = 1'b1; rsp_data = 32'h0000_0093; #1;
    checks++; if (ram_stall !== 1'b0) begin errors++; $display("FAIL ff_stall_rsp got %b exp 0", ram_stall); end
    tick;
    rsp_valid = 1'b0; #1;
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL ff_id_valid got %b exp 1", id_valid); end
    checks++; if (id_pc !== 64'h8000_0000) begin errors++; $display("FAIL ff_id_pc got %h exp 80000000", id_pc); end
    checks++; if (id_inst !== 32'h0000_0093) begin errors++; $display("FAIL ff_id_inst got %h exp 00000093", id_inst); end
    checks++; if (req_addr !== 64'h8000_0004) begin errors++; $display("FAIL ff_addr1 got %h exp 80000004", req_addr); end
  endtask

  task automatic test_backpressure;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick; #1;
      checks++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_0004)
        begin errors++; $display("FAIL bp_req cyc %0d got %b/%h exp 1/80000004", i, req_valid, req_addr); end
      checks++; if (ram_stall !== 1'b1) begin errors++; $display("FAIL bp_stall cyc %0d got %b exp 1", i, ram_stall); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL bp_bubble cyc %0d got %b exp 0", i, id_valid); end
    end
    ready = 1'b1;
    tick;
  endtask

  task automatic test_stall_hold;
    stall = 6'b000011; rsp_valid = 1'b1; rsp_data = 32'h0000_0113;
    for (int i = 0; i < 3; i++) begin
      tick;
      rsp_valid = 1'b0; #1;
      checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL hold_req cyc %0d got %b exp 0", i, req_valid); end
      checks++; if (ram_stall !== 1'b0) begin errors++; $display("FAIL hold_stall cyc %0d got %b exp 0", i, ram_stall); end
      checks++; if (id_valid !== 1'b0 || id_pc !== 64'h8000_0000 || id_inst !== 32'h0000_0093)
        begin errors++; $display("FAIL hold_ifid cyc %0d got %b/%h/%h exp 0/80000000/00000093", i, id_valid, id_pc, id_inst); end
    end
    stall = '0;
    tick; #1;
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'h8000_0004 || id_inst !== 32'h0000_0113)
      begin errors++; $display("FAIL hold_release got %b/%h/%h exp 1/80000004/00000113", id_valid, id_pc, id_inst); end
    checks++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_0008)
      begin errors++; $display("FAIL hold_next_addr got %b/%h exp 1/80000008", req_valid, req_addr); end
  endtask

  task automatic test_redirect_wait;
    tick;
    redir_v = 1'b1; redir_pc = 64'h8000_0100;
    tick;
    redir_v = 1'b0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rw_clear got %b exp 0", id_valid); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rw_wait got %b exp 0", req_valid); end
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    tick;
    rsp_valid = 1'b0; #1;
    checks++; if (id_valid !== 1'b0 || id_inst !== 32'h0000_0113)
      begin errors++; $display("FAIL rw_drop got %b/%h exp 0/00000113", id_valid, id_inst); end
    checks++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_0100)
      begin errors++; $display("FAIL rw_addr got %b/%h exp 1/80000100", req_valid, req_addr); end
  endtask

  task automatic test_flush;
    tick;
    rsp_valid = 1'b1; rsp_data = 32'h0000_0213;
    tick;
    rsp_valid = 1'b0; #1;
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'h8000_0100)
      begin errors++; $display("FAIL fl_pre got %b/%h exp 1/80000100", id_valid, id_pc); end
    flush = 6'b000010;
    tick;
    flush = '0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fl_clear got %b exp 0", id_valid); end
    rsp_valid = 1'b1; rsp_data = 32'h0000_0313;
    tick;
    rsp_valid = 1'b0; #1;
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'h8000_0104 || id_inst !== 32'h0000_0313)
      begin errors++; $display("FAIL fl_post got %b/%h/%h exp 1/80000104/00000313", id_valid, id_pc, id_inst); end
    checks++; if (req_addr !== 64'h8000_0108) begin errors++; $display("FAIL fl_addr got %h exp 80000108", req_addr); end
  endtask

  task automatic test_pc_wrap;
    ready = 1'b0; redir_v = 1'b1; redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick;
    redir_v = 1'b0; ready = 1'b1; #1;
    checks++; if (req_valid !== 1'b1 || req_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
      begin errors++; $display("FAIL wrap_req got %b/%h exp 1/fffffffffffffffc", req_valid, req_addr); end
    tick;
    rsp_valid = 1'b1; rsp_data = 32'h0000_0413;
    tick;
    rsp_valid = 1'b0; #1;
    checks++; if (id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || id_inst !== 32'h0000_0413)
      begin errors++; $display("FAIL wrap_ifid got %h/%h exp fffffffffffffffc/00000413", id_pc, id_inst); end
    checks++; if (req_addr !== 64'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", req_addr); end
  endtask

  task automatic test_redirect_handshake;
    redir_v = 1'b1; redir_pc = 64'h8000_0200;
    tick;
    redir_v = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0000_0513; #1;
    checks++; if (ram_stall !== 1'b1) begin errors++; $display("FAIL rh_stall got %b exp 1", ram_stall); end
    tick;
    rsp_valid = 1'b0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rh_drop got %b exp 0", id_valid); end
    checks++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_0200)
      begin errors++; $display("FAIL rh_addr got %b/%h exp 1/80000200", req_valid, req_addr); end
  endtask

  task automatic test_misalign;
    redir_v = 1'b1; redir_pc = 64'h8000_0102;
    tick;
    redir_v = 1'b0; #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL mis_req0 got %b exp 0", req_valid); end
    rsp_valid = 1'b1; rsp_data = 32'h0000_0613;
    tick;
    rsp_valid = 1'b0; #1;
`ifdef IFU_MISALIGN_EXC_EN
    checks++; if (id_valid !== 1'b1 || id_exc !== 1'b1 || id_inst !== 32'h0000_0013 || id_pc !== 64'h8000_0102)
      begin errors++; $display("FAIL mis_ifid got %b/%b/%h/%h exp 1/1/00000013/80000102", id_valid, id_exc, id_inst, id_pc); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL mis_req1 got %b exp 0", req_valid); end
    tick; #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL mis_idle got %b exp 0", req_valid); end
`else
    checks++; if (id_valid !== 1'b0 || id_exc !== 1'b0)
      begin errors++; $display("FAIL mis_ifid got %b/%b exp 0/0", id_valid, id_exc); end
    checks++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_0100)
      begin errors++; $display("FAIL mis_forced got %b/%h exp 1/80000100", req_valid, req_addr); end
`endif
  endtask

  task automatic test_reset_midflight;
    tick;
    rst_n = 1'b0; #1;
    checks++; if (req_valid !== 1'b0 || id_valid !== 1'b0 || id_pc !== 64'h0 || id_exc !== 1'b0)
      begin errors++; $display("FAIL mid_rst got %b/%b/%h/%b exp 0/0/0/0", req_valid, id_valid, id_pc, id_exc); end
    tick;
    rst_n = 1'b1; rsp_valid = 1'b1; rsp_data = 32'h0000_0713;
    tick;
    rsp_valid = 1'b0; #1;
    checks++; if (id_valid !== 1'b0 || id_inst !== 32'h0)
      begin errors++; $display("FAIL mid_ignore got %b/%h exp 0/0", id_valid, id_inst); end
    checks++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_0000)
      begin errors++; $display("FAIL mid_restart got %b/%h exp 1/80000000", req_valid, req_addr); end
  endtask

  initial begin
    test_reset;
    test_first_fetch;
    test_backpressure;
    test_stall_hold;
    test_redirect_wait;
    test_flush;
    test_pc_wrap;
    test_redirect_handshake;
    test_misalign;
    test_reset_midflight;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_stage.md
Name: ifu_fetch_stage

Overview:
- Instruction-fetch stage: owns the PC, issues fetch requests to the memory arbiter and delivers instructions into the IF/ID register.
- Consumer of the pipeline controller's stall/flush vectors. Producer of its IF-side stall request.
- Sits between the arbiter's instruction port and the ID stage. Redirects from EX (branch/jump) and WB (trap) are applied here.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 64'h8000_0000, first fetch address after reset.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- stall_i  in  6  controller stall vector; [0]=PC, [1]=IF/ID
- flush_i  in  6  controller flush vector; [1]=IF/ID
- redirect_valid_i  in  1  next-PC override (jump/trap), single-cycle pulse
- redirect_pc_i  in  XLEN  override target
- if_req_valid_o  out  1  fetch request to arbiter
- if_req_addr_o  out  XLEN  fetch address
- if_req_ready_i  in  1  arbiter accepts request
- if_rsp_valid_i  in  1  read data valid, one cycle per accepted request
- if_rsp_data_i  in  INST_W  read data
- ram_stall_valid_if_o  out  1  IF-side stall request to controller
- if_id_valid_o  out  1  IF/ID slot holds a real instruction
- if_id_pc_o  out  XLEN  PC of slot
- if_id_inst_o  out  INST_W  instruction of slot
- if_id_exc_o  out  1  misaligned-fetch flag (optional feature)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; state=IDLE; if_req_valid_o=0; ram_stall_valid_if_o=0; if_id_valid_o=0; if_id_pc_o=0; if_id_inst_o=0; if_id_exc_o=0; drop flag=0; inst buffer empty.
- Deassertion mid-transaction: any arbiter response still in flight is ignored; the FSM starts clean.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: go to REQ the next cycle.
  - REQ: if_req_valid_o=1, if_req_addr_o=pc. Both stay stable until if_req_ready_i. Handshake in the same cycle → WAIT.
  - WAIT: on if_rsp_valid_i with drop=0, capture data into the buffer. If stall_i[0]=0, go to REQ with pc+=4; otherwise go to HOLD.
  - WAIT with drop=1: discard the response, clear drop, go to REQ with the already-updated pc.
  - HOLD: buffer valid. When stall_i[0]=0 (buffer consumed into IF/ID), pc+=4 and go to REQ.
- Redirect (redirect_valid_i=1), highest priority over normal PC update, any state:
  - pc<=redirect_pc_i and buffer cleared.
  - In WAIT with no response this cycle: set drop=1, because bus transactions cannot be cancelled.
  - In REQ with no handshake yet: the address changes next cycle; the request is permitted to change because no ready was seen.
  - In REQ with a handshake this cycle: go to WAIT with drop=1.
  - In HOLD or IDLE: go to REQ.
- IF/ID register update, evaluated in priority order each cycle:
  1. flush_i[1] or redirect_valid_i → if_id_valid_o=0.
  2. stall_i[1] → hold all fields.
  3. Instruction available (buffer valid, or response captured this cycle with drop=0) → load pc/inst, valid=1.
  4. Otherwise → bubble (valid=0, pc/inst hold).
- ram_stall_valid_if_o=1 while state is REQ or WAIT and no valid instruction is available this cycle. It is combinational from state and response.
- PC arithmetic: pc+4 wraps modulo 2^XLEN with no saturation.
- A response arriving outside WAIT is ignored.
- Steady state: each instruction takes at least 2 cycles (REQ + WAIT), with no fetch pipelining.

Optional Feature:
- Macro: IFU_MISALIGN_EXC_EN.
- Defined:
  - A redirect with redirect_pc_i[1:0]!=0 issues no bus request.
  - The next IF/ID load (subject to the flush/stall rules) writes valid=1, pc=redirect_pc_i, inst=32'h0000_0013 (nop), if_id_exc_o=1.
  - The FSM then stays in IDLE until the next redirect.
- Undefined: if_id_exc_o tied 0; redirect_pc_i[1:0] forced to 0 before use.

Test Plan:
- Reset release, arbiter always ready, 1-cycle response 32'h0000_0093 → first request addr 0x8000_0000. IF/ID gets valid=1, pc=0x8000_0000; next request addr 0x8000_0004.
- Arbiter holds ready=0 for 5 cycles → if_req_addr_o stable and ram_stall_valid_if_o=1 throughout; if_id_valid_o=0 bubbles.
- stall_i=6'b000011 for 3 cycles while a response arrives → state HOLD, no new request, IF/ID unchanged. Release → buffered instruction loads, next addr = pc+4.
- redirect_valid_i pulse to 0x8000_0100 while in WAIT → the late response is dropped (IF/ID stays 0). Next request addr 0x8000_0100.
- flush_i[1]=1 with a valid slot → if_id_valid_o=0 next cycle; the PC sequence is unaffected.
- With IFU_MISALIGN_EXC_EN: redirect to 0x8000_0102 → no if_req_valid_o. IF/ID gets valid=1, exc=1, inst=0x0000_0013.
